// File: rtl/hsv_core_pkg.sv
// Shared types for the CSR register-file bus arbiter.
package hsv_core_pkg;

    localparam int unsigned CSR_ADDR_W = 16;
    localparam int unsigned CSR_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } csr_arb_state_t;

    typedef struct packed {
        logic                  is_wr;
        logic [CSR_ADDR_W-1:0] addr;
        logic [CSR_DATA_W-1:0] wr_data;
        logic [CSR_DATA_W-1:0] wr_biten;
    } csr_bus_req_t;

endpackage

// File: rtl/hsv_core_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping modulo N.
module hsv_core_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin : p_pick
        int unsigned j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr_i) + i) % N;
            if (!valid_o && req_i[j[IW-1:0]]) begin
                valid_o            = 1'b1;
                idx_o              = j[IW-1:0];
                gnt_o[j[IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hsv_core_ctrlstatus_regs_arbiter.sv
// Round-robin arbiter sharing the CSR register-file bus among N_REQ requesters, one transaction
// outstanding at a time. Optional ack timeout is enabled with `define HSV_CSR_ARB_TIMEOUT_EN.
module hsv_core_ctrlstatus_regs_arbiter
    import hsv_core_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_core,
    input  logic                  rst_core_n,

    input  logic [N_REQ-1:0]      up_req,
    input  logic [N_REQ-1:0]      up_is_wr,
    input  logic [N_REQ*16-1:0]   up_addr,
    input  logic [N_REQ*32-1:0]   up_wr_data,
    input  logic [N_REQ*32-1:0]   up_wr_biten,
    output logic [N_REQ-1:0]      up_stall_rd,
    output logic [N_REQ-1:0]      up_stall_wr,
    output logic [N_REQ-1:0]      up_rd_ack,
    output logic [N_REQ-1:0]      up_rd_err,
    output logic [N_REQ-1:0]      up_wr_ack,
    output logic [N_REQ-1:0]      up_wr_err,
    output logic [31:0]           up_rd_data,

    output logic                  regs_req,
    output logic                  regs_req_is_wr,
    output logic [15:0]           regs_addr,
    output logic [31:0]           regs_wr_data,
    output logic [31:0]           regs_wr_biten,
    input  logic                  regs_req_stall_rd,
    input  logic                  regs_req_stall_wr,
    input  logic                  regs_rd_ack,
    input  logic                  regs_rd_err,
    input  logic [31:0]           regs_rd_data,
    input  logic                  regs_wr_ack,
    input  logic                  regs_wr_err
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    csr_arb_state_t  state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;

    csr_bus_req_t     req_arr [N_REQ];
    csr_bus_req_t     win;
    logic             accept;
    logic             ack_en;
    logic [IW-1:0]    ack_idx;

`ifdef HSV_CSR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    // Only the timeout path needs to know which ack kind to fake.
    logic             owner_is_wr_q, owner_is_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
`endif

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (32'(i) == N_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_arr[i].is_wr    = up_is_wr[i];
            req_arr[i].addr     = up_addr[i*CSR_ADDR_W +: CSR_ADDR_W];
            req_arr[i].wr_data  = up_wr_data[i*CSR_DATA_W +: CSR_DATA_W];
            req_arr[i].wr_biten = up_wr_biten[i*CSR_DATA_W +: CSR_DATA_W];
        end
    end

    hsv_core_rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req_i   (up_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign win        = req_arr[arb_idx];
    assign up_rd_data = regs_rd_data;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        regs_req       = 1'b0;
        regs_req_is_wr = 1'b0;
        regs_addr      = '0;
        regs_wr_data   = '0;
        regs_wr_biten  = '0;
        up_stall_rd    = '1;
        up_stall_wr    = '1;
        up_rd_ack      = '0;
        up_rd_err      = '0;
        up_wr_ack      = '0;
        up_wr_err      = '0;
        accept         = 1'b0;
        ack_en         = 1'b0;
        ack_idx        = owner_q;
`ifdef HSV_CSR_ARB_TIMEOUT_EN
        owner_is_wr_d  = owner_is_wr_q;
        cnt_d          = cnt_q;
        timeout        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    regs_req       = 1'b1;
                    regs_req_is_wr = win.is_wr;
                    regs_addr      = win.addr;
                    regs_wr_data   = win.wr_data;
                    regs_wr_biten  = win.wr_biten;
                    up_stall_rd    = ~arb_gnt | {N_REQ{regs_req_stall_rd}};
                    up_stall_wr    = ~arb_gnt | {N_REQ{regs_req_stall_wr}};
                    accept         = ~(win.is_wr ? regs_req_stall_wr : regs_req_stall_rd);
                end
                // Acks with nothing accepted are stray and dropped.
                if (accept) begin
                    owner_d = arb_idx;
`ifdef HSV_CSR_ARB_TIMEOUT_EN
                    owner_is_wr_d = win.is_wr;
                    cnt_d         = '0;
`endif
                    if (regs_rd_ack || regs_wr_ack) begin
                        ack_en   = 1'b1;
                        ack_idx  = arb_idx;
                        rr_ptr_d = next_idx(arb_idx);
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (regs_rd_ack || regs_wr_ack) begin
                    ack_en   = 1'b1;
                    rr_ptr_d = next_idx(owner_q);
                    state_d  = IDLE;
                end
`ifdef HSV_CSR_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout  = 1'b1;
                    rr_ptr_d = next_idx(owner_q);
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Downstream ack kind is forwarded as received, even if it mismatches the request.
        if (ack_en) begin
            up_rd_ack[ack_idx] = regs_rd_ack;
            up_rd_err[ack_idx] = regs_rd_ack & regs_rd_err;
            up_wr_ack[ack_idx] = regs_wr_ack;
            up_wr_err[ack_idx] = regs_wr_ack & regs_wr_err;
        end
`ifdef HSV_CSR_ARB_TIMEOUT_EN
        if (timeout) begin
            up_rd_ack[owner_q] = ~owner_is_wr_q;
            up_rd_err[owner_q] = ~owner_is_wr_q;
            up_wr_ack[owner_q] = owner_is_wr_q;
            up_wr_err[owner_q] = owner_is_wr_q;
        end
`endif

        if (!rst_core_n) begin
            regs_req       = 1'b0;
            regs_req_is_wr = 1'b0;
            regs_addr      = '0;
            regs_wr_data   = '0;
            regs_wr_biten  = '0;
            up_stall_rd    = '1;
            up_stall_wr    = '1;
            up_rd_ack      = '0;
            up_rd_err      = '0;
            up_wr_ack      = '0;
            up_wr_err      = '0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

`ifdef HSV_CSR_ARB_TIMEOUT_EN
    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            owner_is_wr_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            owner_is_wr_q <= owner_is_wr_d;
            cnt_q         <= cnt_d;
        end
    end
`endif

endmodule

// File: doc/hsv_core_ctrlstatus_regs_arbiter.md
Name: hsv_core_ctrlstatus_regs_arbiter

Overview:
- Shares the single CSR register-file bus (req/stall/ack protocol, 16-bit byte address) among N_REQ requesters.
- Typical requesters: the CSR read/write execution unit, the trap/exception unit and a debug port.
- Round-robin grant, one outstanding transaction at a time.
- Routes read/write acks back to the requester that issued the transaction.

Parameters:
- N_REQ, 2: number of requesters (2..8).
- TIMEOUT_CYCLES, 255: ack timeout in cycles; used only with HSV_CSR_ARB_TIMEOUT_EN.

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  synchronous, active-low reset
- up_req  in  N_REQ  per-requester request
- up_is_wr  in  N_REQ  1 = write, 0 = read
- up_addr  in  N_REQ*16  per-requester address
- up_wr_data  in  N_REQ*32  write data
- up_wr_biten  in  N_REQ*32  write bit enables
- up_stall_rd  out  N_REQ  read stall to each requester
- up_stall_wr  out  N_REQ  write stall to each requester
- up_rd_ack  out  N_REQ  one-hot read ack
- up_rd_err  out  N_REQ  read error, qualified by up_rd_ack
- up_wr_ack  out  N_REQ  one-hot write ack
- up_wr_err  out  N_REQ  write error, qualified by up_wr_ack
- up_rd_data  out  32  read data, broadcast to all requesters
- regs_req  out  1  downstream request
- regs_req_is_wr  out  1  downstream write flag
- regs_addr  out  16  downstream address
- regs_wr_data  out  32  downstream write data
- regs_wr_biten  out  32  downstream bit enables
- regs_req_stall_rd  in  1  downstream read stall
- regs_req_stall_wr  in  1  downstream write stall
- regs_rd_ack  in  1  downstream read ack
- regs_rd_err  in  1  downstream read error
- regs_rd_data  in  32  downstream read data
- regs_wr_ack  in  1  downstream write ack
- regs_wr_err  in  1  downstream write error

Behaviour:
- Reset: synchronous, on rst_core_n low at the clk_core edge. Sets state=IDLE, rr_ptr=0, owner=0.
  - While rst_core_n is low: regs_req=0, all up_*_ack=0, all up_stall_*=1.
  - Remaining downstream fields are don't-care but driven 0.
- State machine: IDLE, WAIT_ACK.
- IDLE:
  - winner = first asserted up_req at or after rr_ptr, wrapping modulo N_REQ. Combinational, same cycle.
  - Winner's is_wr/addr/wr_data/wr_biten drive the downstream bus; regs_req=1 if any up_req is asserted.
  - Winner's up_stall_rd/up_stall_wr pass through regs_req_stall_rd/regs_req_stall_wr. Non-winners see both stalls = 1.
  - Accept when regs_req & ~(is_wr ? regs_req_stall_wr : regs_req_stall_rd). On accept: owner<=winner, owner_is_wr<=is_wr, state<=WAIT_ACK.
  - Unaccepted requests may be withdrawn (flush); arbitration re-evaluates every cycle with no penalty.
- WAIT_ACK:
  - regs_req=0, all up_stall_*=1.
  - On regs_rd_ack or regs_wr_ack: pulse the matching up_*_ack[owner] with its err bit in the same cycle (combinational route). Then rr_ptr<=(owner+1) mod N_REQ and state<=IDLE.
  - The next grant is possible the cycle after the ack, giving a 1-cycle bubble.
- Same-cycle ack: a downstream ack in the same cycle as acceptance is legal. It is routed to the winner, rr_ptr advances, and state stays IDLE.
- Mismatched ack: an ack of the wrong kind (rd_ack for a write) is still routed to owner as received. An ack while nothing is outstanding is dropped.
- Requesters must not drop up_req after acceptance. The ack is still delivered.
- up_rd_data = regs_rd_data unconditionally.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,…,N_REQ-1,0.

Optional Feature:
- Macro: HSV_CSR_ARB_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on accept and increments in WAIT_ACK.
  - On reaching TIMEOUT_CYCLES without an ack: pulse up_rd_ack or up_wr_ack[owner] per owner_is_wr, with err=1, and return to IDLE.
  - Late downstream acks arriving afterwards are dropped.
- Not defined: WAIT_ACK waits indefinitely; no counter is instantiated.

Decomposition:
- hsv_core_pkg: csr_arb_state_t enum {IDLE, WAIT_ACK}; csr_bus_req_t struct {is_wr, addr[15:0], wr_data, wr_biten}.
- Sub-module hsv_core_rr_arbiter (parameter N; inputs req vector and ptr; outputs one-hot grant and index). Purely combinational, reusable elsewhere.

Test Plan:
- Single read: r0 reads addr 0x3000 with no stall, rd_ack two cycles later, rd_data=0xDEADBEEF → up_rd_ack=01, up_rd_data=0xDEADBEEF, no ack to r1.
- Contention: r0 and r1 both request continuously, eight transactions → grant order 0,1,0,1,0,1,0,1 with a 1-cycle bubble after each ack.
- Stall: r1 write with regs_req_stall_wr held 3 cycles → up_stall_wr[1]=1 for 3 cycles, accepted cycle 4, up_stall_wr[0]=1 throughout.
- Zero-latency: wr_ack with wr_err=1 in the acceptance cycle → up_wr_ack[0]=1, up_wr_err[0]=1 same cycle, next grant the following cycle.
- Flush: r0 drops req while stalled → regs_req falls; r1 is granted next cycle without waiting.
- Reset mid-WAIT_ACK: rst_core_n low for one edge → state IDLE, rr_ptr=0, later stray ack dropped. With HSV_CSR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack → err ack on cycle 4.
